// File: rtl/ascon_pkg.sv
// ascon_pkg -- shared definitions for the masked Ascon hash controller and
// related blocks (AEAD tag check reuses ct_compare and these widths).
//   Y_DEF      default message / mask width (matches hash core y)
//   L_DEF      default digest width (matches hash core l)
//   TO_W_DEF   default timeout counter width
//   TO_MAX_DEF default timeout, in cycles spent in WAIT or DRAIN
//   state_t    controller state encoding; IDLE must stay 0 so reset lands there
package ascon_pkg;

  localparam int          Y_DEF      = 40;
  localparam int          L_DEF      = 256;
  localparam int          TO_W_DEF   = 16;
  localparam logic [15:0] TO_MAX_DEF = 16'd4000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RELEASE = 3'd4,
    S_DRAIN   = 3'd5,
    S_RESP    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

endpackage

// File: rtl/ct_compare.sv
// ct_compare -- constant-time equality of two W-bit words.
// Full-width XOR then OR-reduce: no early exit, no data-dependent path,
// so the compare leaks nothing about where (or whether) the words differ.
//   a, b  words to compare
//   eq    1 when a == b
module ct_compare #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  logic [W-1:0] diff;

  assign diff = a ^ b;
  assign eq   = ~|diff;

endmodule

// File: rtl/hash_verify_ctrl.sv
// hash_verify_ctrl -- drives the masked Ascon hash core for one verify
// request at a time: latch request, pulse start, wait for the digest,
// compare it against the expected value in constant time, pulse start
// again to return the core to idle, then report match / mismatch.
// A core that never answers (WAIT or DRAIN lasting TO_MAX cycles) yields a
// single fault response, after which the block refuses work until reset.
//   clk, rst          clock, asynchronous active-low reset
//   req_*             request: valid/ready, message, expected digest, masks
//   hs_message/rnd_*  held operands towards the core
//   hs_start          single-cycle start pulses (launch and release)
//   hs_ready, hs_hash core done flag and digest
//   resp_*            response: valid/ready, match, fault
//   busy              controller not idle
module hash_verify_ctrl
  import ascon_pkg::*;
#(
  parameter int              Y      = Y_DEF,
  parameter int              L      = L_DEF,
  parameter int              TO_W   = TO_W_DEF,
  parameter logic [TO_W-1:0] TO_MAX = TO_W'(TO_MAX_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [Y-1:0] req_msg,
  input  logic [L-1:0] req_exp,
  input  logic [Y-1:0] req_rnd1,
  input  logic [Y-1:0] req_rnd2,
  output logic [Y-1:0] hs_message,
  output logic [Y-1:0] hs_random_m1,
  output logic [Y-1:0] hs_random_m2,
  output logic         hs_start,
  input  logic         hs_ready,
  input  logic [L-1:0] hs_hash,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_match,
  output logic         resp_fault,
  output logic         busy
);

  state_t          state, nxt;
  logic [Y-1:0]    msg_q, rnd1_q, rnd2_q;
  logic [L-1:0]    exp_q;
  logic [TO_W-1:0] cnt, cnt_inc;
  logic            fault_done, fault_done_d;
  logic            eq, accept, ack;
  logic            req_ready_d, hs_start_d, resp_valid_d, resp_fault_d, busy_d;

  assign hs_message   = msg_q;
  assign hs_random_m1 = rnd1_q;
  assign hs_random_m2 = rnd2_q;

  ct_compare #(.W(L)) u_cmp (
    .a  (hs_hash),
    .b  (exp_q),
    .eq (eq)
  );

  assign accept  = (state == S_IDLE) && req_valid && req_ready;
  assign ack     = resp_valid && resp_ready;
  // timeout fires on the TO_MAX-th consecutive cycle in WAIT / DRAIN
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (accept) nxt = S_LAUNCH;
      S_LAUNCH:  nxt = S_WAIT;
      S_WAIT:    if (hs_ready) nxt = S_CAPTURE;          // ready beats timeout
                 else if (cnt_inc == TO_MAX) nxt = S_FAULT;
      S_CAPTURE: nxt = S_RELEASE;
      S_RELEASE: nxt = S_DRAIN;
      S_DRAIN:   if (!hs_ready) nxt = S_RESP;
                 else if (cnt_inc == TO_MAX) nxt = S_FAULT;
      S_RESP:    if (resp_ready) nxt = S_IDLE;
      S_FAULT:   nxt = S_FAULT;                          // only reset leaves
      default:   nxt = S_IDLE;
    endcase

    // fault response is offered once; afterwards FAULT is silent
    fault_done_d = fault_done | ((state == S_FAULT) && ack);

    // outputs are registered from the next state so they line up with it
    req_ready_d  = (nxt == S_IDLE);
    hs_start_d   = (nxt == S_LAUNCH) || (nxt == S_RELEASE);
    resp_fault_d = (nxt == S_FAULT) && !fault_done_d;
    resp_valid_d = (nxt == S_RESP) || resp_fault_d;
    busy_d       = (nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      fault_done <= 1'b0;
      req_ready  <= 1'b0;
      hs_start   <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      fault_done <= fault_done_d;
      req_ready  <= req_ready_d;
      hs_start   <= hs_start_d;
      resp_valid <= resp_valid_d;
      resp_fault <= resp_fault_d;
      busy       <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q      <= '0;
      rnd1_q     <= '0;
      rnd2_q     <= '0;
      exp_q      <= '0;
      cnt        <= '0;
      resp_match <= 1'b0;
    end else begin
      if (accept) begin
        msg_q  <= req_msg;
        rnd1_q <= req_rnd1;
        rnd2_q <= req_rnd2;
        exp_q  <= req_exp;
      end

      if (state == S_LAUNCH || state == S_RELEASE) cnt <= '0;
      else if (state == S_WAIT || state == S_DRAIN) cnt <= cnt_inc;

      // expected digest is single-use: wipe it as soon as it is consumed
      if (state == S_CAPTURE) begin
        resp_match <= eq;
        exp_q      <= '0;
      end

      if (state == S_RESP && resp_ready) begin
        resp_match <= 1'b0;
        msg_q      <= '0;
        rnd1_q     <= '0;
        rnd2_q     <= '0;
      end

      // a late fault (DRAIN) must not expose an earlier match
      if (nxt == S_FAULT) resp_match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hash_verify_ctrl.sv
// tb_hash_verify_ctrl -- directed bench for hash_verify_ctrl with a
// behavioural hash core stub and a transaction-level reference model.
module tb_hash_verify_ctrl;

  localparam int Y   = 40;
  localparam int L   = 256;
  localparam int TOM = 50;
  localparam logic [L-1:0] D =
    256'hDEAD_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_BEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [Y-1:0] req_msg = '0, req_rnd1 = '0, req_rnd2 = '0;
  logic [L-1:0] req_exp = '0;
  logic [Y-1:0] hs_message, hs_random_m1, hs_random_m2;
  logic         hs_start;
  logic         hs_ready;
  logic [L-1:0] hs_hash;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic         resp_match, resp_fault, busy;

  always #5 clk = ~clk;

  hash_verify_ctrl #(.Y(Y), .L(L), .TO_W(16), .TO_MAX(16'd50)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_exp(req_exp), .req_rnd1(req_rnd1), .req_rnd2(req_rnd2),
    .hs_message(hs_message), .hs_random_m1(hs_random_m1), .hs_random_m2(hs_random_m2),
    .hs_start(hs_start), .hs_ready(hs_ready), .hs_hash(hs_hash),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_match(resp_match), .resp_fault(resp_fault), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- hash core stub ----------------
  // ready appears `lat` cycles after the launch pulse is presented; a start
  // pulse while ready is the release that drops ready again.
  int   lat = 40;
  bit   hang = 1'b0;
  int   n_starts = 0;
  logic s_run = 1'b0, s_ready = 1'b0;
  int   s_cnt = 0;

  assign hs_ready = s_ready;
  assign hs_hash  = s_ready ? D : ~D;

  always @(posedge clk) begin
    if (!rst) begin
      s_run   <= 1'b0;
      s_ready <= 1'b0;
      s_cnt   <= 0;
    end else if (hs_start) begin
      n_starts <= n_starts + 1;
      if (s_ready) s_ready <= 1'b0;
      else begin
        s_run <= 1'b1;
        s_cnt <= 0;
      end
    end else if (s_run && !hang) begin
      if (s_cnt == lat - 2) begin
        s_ready <= 1'b1;
        s_run   <= 1'b0;
      end
      s_cnt <= s_cnt + 1;
    end
  end

  // ---------------- reference model + compare ----------------
  // One transaction at a time. Accept at the edge after a negedge that sees
  // valid & ready; response visible core latency + 4 cycles after that
  // edge, or TO_MAX + 1 cycles after it when the core never answers.
  int           ncyc = 0;
  bit           m_active = 0, m_locked = 0, m_fresh = 1, m_fault = 0, m_match = 0;
  int           m_acc = 0, m_resp_at = 0;
  logic [Y-1:0] m_msg = '0, m_r1 = '0, m_r2 = '0;
  bit           exp_rr, exp_rv, exp_st;

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      chk("reset_outputs",
          {req_ready, hs_start, resp_valid, resp_match, resp_fault, busy,
           hs_message, hs_random_m1, hs_random_m2}, '0);
      m_active = 0;
      m_locked = 0;
      m_fresh  = 1;
    end else begin
      exp_rr = !m_fresh && !m_active && !m_locked;
      exp_rv = m_active && (ncyc >= m_resp_at);
      exp_st = m_active && ((ncyc == m_acc + 1) || (!m_fault && ncyc == m_resp_at - 2));
      chk("req_ready", req_ready, exp_rr);
      chk("busy", busy, m_active || m_locked);
      chk("resp_valid", resp_valid, exp_rv);
      chk("hs_start", hs_start, exp_st);
      if (exp_rv) begin
        chk("resp_match", resp_match, m_match);
        chk("resp_fault", resp_fault, m_fault);
      end else begin
        chk("resp_fault_idle", resp_fault, 1'b0);
      end
      if (m_active && ncyc < m_resp_at)
        chk("hs_operands_held", {hs_message, hs_random_m1, hs_random_m2}, {m_msg, m_r1, m_r2});
      else if (!m_active && !m_locked)
        chk("hs_operands_zero", {hs_message, hs_random_m1, hs_random_m2}, '0);

      if (exp_rv && resp_ready) begin
        if (m_fault) m_locked = 1;
        m_active = 0;
      end else if (exp_rr && req_valid) begin
        m_active  = 1;
        m_acc     = ncyc;
        m_msg     = req_msg;
        m_r1      = req_rnd1;
        m_r2      = req_rnd2;
        m_fault   = hang || (lat > TOM);
        m_match   = !m_fault && (req_exp == D);
        m_resp_at = m_fault ? ncyc + TOM + 2 : ncyc + lat + 5;
      end
      m_fresh = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic present(input logic [Y-1:0] msg, input logic [L-1:0] exp,
                         input logic [Y-1:0] r1, input logic [Y-1:0] r2);
    @(posedge clk); #1;
    req_msg = msg; req_exp = exp; req_rnd1 = r1; req_rnd2 = r2;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(output int acc);
    bit ok = 0;
    acc = -1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #1;
      if (m_active && m_acc == ncyc) begin ok = 1; acc = ncyc; end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int rn, output bit mt, output bit ft);
    bit ok = 0;
    rn = -1; mt = 0; ft = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #1;
      if (resp_valid) begin ok = 1; rn = ncyc; mt = resp_match; ft = resp_fault; end
    end
    if (!ok) chk("resp_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_txn(input logic [Y-1:0] msg, input logic [L-1:0] exp,
                         input logic [Y-1:0] r1, input logic [Y-1:0] r2,
                         output int diff, output bit mt, output bit ft, output int st);
    int s0, acc, rn;
    s0 = n_starts;
    present(msg, exp, r1, r2);
    wait_accept(acc);
    // request-side inputs change while the core works; core side must not
    req_msg = ~msg; req_rnd1 = ~r1; req_rnd2 = r1 ^ r2; req_exp = ~exp;
    wait_resp(rn, mt, ft);
    @(posedge clk); #1;
    diff = rn - acc - 1;
    st   = n_starts - s0;
  endtask

  int diff, st, acc, rn, hs_n;
  bit mt, ft;
  logic [L-1:0] msb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    msb = '0;
    msb[L-1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // match
    lat = 40;
    run_txn(40'h0123456789, D, 40'hA5A5A5A5A5, 40'h3C3C3C3C3C, diff, mt, ft, st);
    chk("match_latency", diff, 44);
    chk("match_result", mt, 1'b1);
    chk("match_fault", ft, 1'b0);
    chk("match_starts", st, 2);

    // mismatch in LSB only: same timing
    run_txn(40'h0123456789, D ^ 256'h1, 40'hA5A5A5A5A5, 40'h3C3C3C3C3C, diff, mt, ft, st);
    chk("lsb_mismatch_latency", diff, 44);
    chk("lsb_mismatch_result", mt, 1'b0);
    chk("lsb_mismatch_starts", st, 2);

    // mismatch in MSB only
    run_txn(40'hFFFFFFFFFF, D ^ msb, 40'h0000000001, 40'h8000000000, diff, mt, ft, st);
    chk("msb_mismatch_result", mt, 1'b0);
    chk("msb_mismatch_latency", diff, 44);

    // ready arrives on the very cycle the timeout would fire: ready wins
    lat = 50;
    run_txn(40'h5A5A5A5A5A, D, 40'h1234567890, 40'h0987654321, diff, mt, ft, st);
    chk("boundary_latency", diff, 54);
    chk("boundary_result", mt, 1'b1);
    chk("boundary_fault", ft, 1'b0);
    lat = 40;

    // backpressure: response held 20 cycles while the next request waits
    resp_ready = 1'b0;
    present(40'h1111111111, D, 40'h2222222222, 40'h3333333333);
    wait_accept(acc);
    wait_resp(rn, mt, ft);
    chk("bp_first_latency", rn - acc - 1, 44);
    present(40'h4444444444, D ^ 256'h10, 40'h5555555555, 40'h6666666666);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("bp_resp_held", {resp_valid, resp_match}, 2'b11);
    chk("bp_req_blocked", req_ready, 1'b0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk); #1;
    hs_n = ncyc;
    wait_accept(acc);
    chk("bp_gap", acc > hs_n, 1'b1);
    wait_resp(rn, mt, ft);
    @(posedge clk); #1;
    chk("bp_second_result", mt, 1'b0);

    // asynchronous reset while waiting on the core
    present(40'h0123456789, D, 40'hA5A5A5A5A5, 40'h3C3C3C3C3C);
    wait_accept(acc);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_reset_now",
           {req_ready, hs_start, resp_valid, resp_match, resp_fault, busy,
            hs_message, hs_random_m1, hs_random_m2}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (60) @(posedge clk);

    // core never answers
    hang = 1'b1;
    run_txn(40'h0F0F0F0F0F, D, 40'hF0F0F0F0F0, 40'h00FF00FF00, diff, mt, ft, st);
    chk("timeout_latency", diff, 51);
    chk("timeout_fault", ft, 1'b1);
    chk("timeout_match", mt, 1'b0);
    chk("timeout_starts", st, 1);
    present(40'h0123456789, D, 40'hA5A5A5A5A5, 40'h3C3C3C3C3C);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("fault_locked_ready", req_ready, 1'b0);
    chk("fault_locked_busy", busy, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // normal operation after recovering from the fault
    run_txn(40'h0123456789, D, 40'hA5A5A5A5A5, 40'h3C3C3C3C3C, diff, mt, ft, st);
    chk("recover_latency", diff, 44);
    chk("recover_result", mt, 1'b1);
    chk("recover_starts", st, 2);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
